// File: rtl/tile_sched_pkg.sv
// Shared types and sizing helpers for the tile load scheduler.
package tile_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    READY,
    COMPUTE,
    DONE
  } sched_state_t;

  // Counter width: wide enough to hold the larger word target itself.
  function automatic int unsigned cnt_width(input int unsigned a_words,
                                            input int unsigned b_words);
    return $clog2((a_words > b_words) ? a_words : b_words) + 1;
  endfunction

endpackage

// File: rtl/stream_fill_counter.sv
// Accepts up to TARGET words from one valid/ready stream and turns each
// handshake into a registered buffer write at the pre-increment count.
module stream_fill_counter
  import tile_sched_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned TARGET = 2048,
  parameter int unsigned CNT_W  = cnt_width(TARGET, 1),
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              arst_in,
  input  logic              clear,
  input  logic              valid,
  input  logic [WIDTH-1:0]  data,
  output logic              ready,
  output logic              full,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  wdata
);

  localparam logic [CNT_W-1:0] TGT = CNT_W'(TARGET);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              hs;

  // Handshake, count update and write-port capture.
  always_comb begin
    ready   = (cnt_q < TGT);
    hs      = valid && ready;
    cnt_d   = cnt_q;
    we_d    = hs;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (clear) begin
      cnt_d = '0;
    end else if (hs) begin
      cnt_d   = cnt_q + CNT_W'(1);
      addr_d  = ADDR_W'(cnt_q);
      wdata_d = data;
    end
    // Looks at the next count so the owner can leave FILL on the last handshake.
    full = (cnt_d == TGT);
  end

  // Count and write-port registers.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

// File: rtl/tile_load_scheduler.sv
// Fills the A/B tile buffers from two streams, hands each tile to the conv
// controller and waits for its completion, for NB_TILES tiles per run.
module tile_load_scheduler
  import tile_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned LOG2_BUF_HEIGHT = 12,
  parameter int unsigned A_WORDS         = 2048,
  parameter int unsigned B_WORDS         = 576,
  parameter int unsigned NB_TILES        = 2
) (
  input  logic                       clk,
  input  logic                       arst_in,
  input  logic                       start,
  output logic                       busy,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [DATA_WIDTH-1:0]      a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [DATA_WIDTH-1:0]      b_data,
  output logic                       buf_a_we,
  output logic [LOG2_BUF_HEIGHT-1:0] buf_a_addr,
  output logic [DATA_WIDTH-1:0]      buf_a_wdata,
  output logic                       buf_b_we,
  output logic [LOG2_BUF_HEIGHT-1:0] buf_b_addr,
  output logic [DATA_WIDTH-1:0]      buf_b_wdata,
  input  logic                       ctrl_load_req,
  output logic                       ctrl_data_ready,
  input  logic                       ctrl_fsm_done,
  output logic [31:0]                tile_idx,
  output logic                       run_done
);

  localparam int unsigned CNT_W     = cnt_width(A_WORDS, B_WORDS);
  localparam logic [31:0] LAST_TILE = 32'(NB_TILES - 1);

  sched_state_t state_q, state_d;
  logic [31:0]  tile_idx_q, tile_idx_d;
  logic         done_prev_q, done_prev_d;
  logic         busy_q, busy_d;
  logic         run_done_q, run_done_d;
  logic         clear;
  logic         in_fill;
  logic         done_rise;
  logic         a_rdy, a_full, b_rdy, b_full;

  assign in_fill = (state_q == FILL);

  stream_fill_counter #(
    .WIDTH (DATA_WIDTH),
    .TARGET(A_WORDS),
    .CNT_W (CNT_W),
    .ADDR_W(LOG2_BUF_HEIGHT)
  ) u_a_fill (
    .clk    (clk),
    .arst_in(arst_in),
    .clear  (clear),
    .valid  (a_valid && in_fill),
    .data   (a_data),
    .ready  (a_rdy),
    .full   (a_full),
    .we     (buf_a_we),
    .addr   (buf_a_addr),
    .wdata  (buf_a_wdata)
  );

  stream_fill_counter #(
    .WIDTH (DATA_WIDTH),
    .TARGET(B_WORDS),
    .CNT_W (CNT_W),
    .ADDR_W(LOG2_BUF_HEIGHT)
  ) u_b_fill (
    .clk    (clk),
    .arst_in(arst_in),
    .clear  (clear),
    .valid  (b_valid && in_fill),
    .data   (b_data),
    .ready  (b_rdy),
    .full   (b_full),
    .we     (buf_b_we),
    .addr   (buf_b_addr),
    .wdata  (buf_b_wdata)
  );

  assign a_ready = in_fill && a_rdy;
  assign b_ready = in_fill && b_rdy;

  // Next-state, tile sequencing and controller handshake.
  always_comb begin
    state_d         = state_q;
    tile_idx_d      = tile_idx_q;
    clear           = 1'b0;
    ctrl_data_ready = 1'b0;
    done_rise       = ctrl_fsm_done && !done_prev_q;
    // Edge history is only kept while computing, so it starts cleared on entry.
    done_prev_d     = (state_q == COMPUTE) ? ctrl_fsm_done : 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILL;
          clear      = 1'b1;
          tile_idx_d = '0;
        end
      end
      FILL: begin
        if (a_full && b_full) state_d = READY;
      end
      READY: begin
        ctrl_data_ready = ctrl_load_req;
        if (ctrl_load_req) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (done_rise) begin
          if (tile_idx_q == LAST_TILE) begin
            state_d = DONE;
          end else begin
            state_d    = FILL;
            tile_idx_d = tile_idx_q + 32'd1;
            clear      = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    run_done_d = (state_d == DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q     <= IDLE;
      tile_idx_q  <= '0;
      done_prev_q <= 1'b0;
      busy_q      <= 1'b0;
      run_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_idx_q  <= tile_idx_d;
      done_prev_q <= done_prev_d;
      busy_q      <= busy_d;
      run_done_q  <= run_done_d;
    end
  end

  assign busy     = busy_q;
  assign run_done = run_done_q;
  assign tile_idx = tile_idx_q;

endmodule

// File: tb/tb_tile_load_scheduler.sv
// Directed bench for tile_load_scheduler with default geometry and two tiles.
module tb_tile_load_scheduler;

  localparam int A_W   = 2048;
  localparam int B_W   = 576;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        arst_in = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [15:0] a_data = '0, b_data = '0;
  logic        buf_a_we, buf_b_we;
  logic [11:0] buf_a_addr, buf_b_addr;
  logic [15:0] buf_a_wdata, buf_b_wdata;
  logic        ctrl_load_req = 1'b0;
  logic        ctrl_data_ready;
  logic        ctrl_fsm_done = 1'b0;
  logic [31:0] tile_idx;
  logic        run_done;

  int passes = 0;
  int total  = 0;

  tile_load_scheduler dut (
    .clk            (clk),
    .arst_in        (arst_in),
    .start          (start),
    .busy           (busy),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_data         (b_data),
    .buf_a_we       (buf_a_we),
    .buf_a_addr     (buf_a_addr),
    .buf_a_wdata    (buf_a_wdata),
    .buf_b_we       (buf_b_we),
    .buf_b_addr     (buf_b_addr),
    .buf_b_wdata    (buf_b_wdata),
    .ctrl_load_req  (ctrl_load_req),
    .ctrl_data_ready(ctrl_data_ready),
    .ctrl_fsm_done  (ctrl_fsm_done),
    .tile_idx       (tile_idx),
    .run_done       (run_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fa(input int k);
    return 16'(k * 3 + 16'h1234);
  endfunction

  function automatic logic [15:0] fb(input int k);
    return 16'(k * 5 + 16'h0bad);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one tile's fill from the current negedge; returns at a negedge.
  // stop_a != 0 returns once that many A words have been accepted.
  task automatic fill(input bit rnd, input int stop_a);
    int  a_sent = 0, b_sent = 0, a_wr = 0, b_wr = 0, cyc = 0;
    bit  fin = 1'b0;
    while (!fin) begin
      if (buf_a_we) begin
        chk("a_addr", 32'(buf_a_addr), 32'(a_wr));
        chk("a_wdata", 32'(buf_a_wdata), 32'(fa(a_wr)));
        a_wr++;
      end
      if (buf_b_we) begin
        chk("b_addr", 32'(buf_b_addr), 32'(b_wr));
        chk("b_wdata", 32'(buf_b_wdata), 32'(fb(b_wr)));
        b_wr++;
      end
      if (a_wr >= A_W && b_wr >= B_W) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("ready_entry_a_ready", 32'(a_ready), 32'd0);
        chk("ready_entry_b_ready", 32'(b_ready), 32'd0);
        chk("ready_entry_busy", 32'(busy), 32'd1);
        fin = 1'b1;
      end else if (stop_a != 0 && a_sent == stop_a) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
        fin = 1'b1;
      end else if (cyc >= LIMIT) begin
        chk("fill_timeout_a_writes", 32'(a_wr), 32'(A_W));
        chk("fill_timeout_b_writes", 32'(b_wr), 32'(B_W));
        fin = 1'b1;
      end else begin
        chk("fill_a_ready", 32'(a_ready), 32'(a_sent < A_W));
        chk("fill_b_ready", 32'(b_ready), 32'(b_sent < B_W));
        a_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        b_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        a_data  = fa(a_sent);
        b_data  = fb(b_sent);
        if (a_valid && (a_sent < A_W)) a_sent++;
        if (b_valid && (b_sent < B_W)) b_sent++;
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    // Reset values.
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_a_we", 32'(buf_a_we), 32'd0);
    chk("rst_b_we", 32'(buf_b_we), 32'd0);
    chk("rst_data_ready", 32'(ctrl_data_ready), 32'd0);
    chk("rst_run_done", 32'(run_done), 32'd0);
    chk("rst_tile_idx", tile_idx, 32'd0);
    @(negedge clk);
    arst_in = 1'b0;

    // Tile 0: streams always valid.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t0_busy", 32'(busy), 32'd1);
    chk("t0_tile_idx", tile_idx, 32'd0);
    fill(1'b0, 0);

    // Words offered in READY are back-pressured and never written.
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      b_valid = 1'b1;
      @(negedge clk);
      chk("ready_a_ready", 32'(a_ready), 32'd0);
      chk("ready_b_ready", 32'(b_ready), 32'd0);
      chk("ready_a_we", 32'(buf_a_we), 32'd0);
      chk("ready_b_we", 32'(buf_b_we), 32'd0);
      chk("ready_no_req", 32'(ctrl_data_ready), 32'd0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    ctrl_load_req = 1'b1;
    #1;
    chk("ready_data_ready", 32'(ctrl_data_ready), 32'd1);
    @(negedge clk);
    chk("compute_data_ready", 32'(ctrl_data_ready), 32'd0);
    ctrl_load_req = 1'b0;

    // start during COMPUTE is ignored.
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("compute_start_tile_idx", tile_idx, 32'd0);
      chk("compute_start_busy", 32'(busy), 32'd1);
      chk("compute_start_a_ready", 32'(a_ready), 32'd0);
    end
    start = 1'b0;

    // fsm_done held 5 cycles advances the tile exactly once.
    ctrl_fsm_done = 1'b1;
    @(negedge clk);
    chk("t1_tile_idx", tile_idx, 32'd1);
    chk("t1_a_ready", 32'(a_ready), 32'd1);
    chk("t1_b_ready", 32'(b_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_done_tile_idx", tile_idx, 32'd1);
      chk("held_done_a_we", 32'(buf_a_we), 32'd0);
    end
    ctrl_fsm_done = 1'b0;

    // Tile 1: random gaps, addresses restart at 0.
    fill(1'b1, 0);
    ctrl_load_req = 1'b1;
    @(negedge clk);
    ctrl_load_req = 1'b0;
    ctrl_fsm_done = 1'b1;
    @(negedge clk);
    ctrl_fsm_done = 1'b0;
    chk("run_done_pulse", 32'(run_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_tile_idx", tile_idx, 32'd1);
    @(negedge clk);
    chk("idle_run_done", 32'(run_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_tile_idx", tile_idx, 32'd1);

    // Asynchronous reset mid-fill at a_cnt=100.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("r_start_tile_idx", tile_idx, 32'd0);
    fill(1'b0, 100);
    #2;
    arst_in = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_a_ready", 32'(a_ready), 32'd0);
    chk("arst_b_ready", 32'(b_ready), 32'd0);
    chk("arst_a_we", 32'(buf_a_we), 32'd0);
    chk("arst_a_addr", 32'(buf_a_addr), 32'd0);
    chk("arst_b_we", 32'(buf_b_we), 32'd0);
    chk("arst_run_done", 32'(run_done), 32'd0);
    @(negedge clk);
    arst_in = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fill(1'b1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
